// File: rtl/id_ex_pipe_pkg.sv
// Shared decode/execute definitions: default widths, NOP encodings and zero constants.
// Imported by the ID/EX pipeline register and its testbench.
package id_ex_pipe_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int ADDR_W_DEF  = 32;
   localparam int RADDR_W_DEF = 5;
   localparam int OP_W_DEF    = 7;

   localparam logic [6:0]  ALUOP_NOP    = 7'b0000000;
   localparam logic [2:0]  FUNCT3_NOP   = 3'b000;
   localparam logic [6:0]  FUNCT7_NOP   = 7'b0000000;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;

   // Packed bundle width: pc, aluop, funct3, funct7, reg1, reg2, imm, wreg, wd.
   function automatic int bundle_w(input int xlen, input int addr_w,
                                   input int raddr_w, input int op_w);
      return addr_w + op_w + 3 + 7 + 3 * xlen + 1 + raddr_w;
   endfunction

endpackage

// File: rtl/id_ex_pipe_skid.sv
// Generic 2-entry valid/ready skid buffer with flush; 1-cycle latency, full throughput.
// in_ready is registered (skid empty) so upstream never sees out_ready combinationally.
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);

   logic         out_vld;
   logic         skid_vld;
   logic [W-1:0] out_dat;
   logic [W-1:0] skid_dat;
   logic         accept;
   logic         consume;

   assign accept  = in_valid & ~skid_vld;
   assign consume = out_vld & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         out_dat  <= '0;
         skid_dat <= '0;
      end else if (flush) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (skid_vld) begin
         // Skid full means in_ready is low, so only a drain can happen here.
         if (consume) begin
            out_dat  <= skid_dat;
            skid_vld <= 1'b0;
         end
      end else if (accept) begin
         if (!out_vld || consume) begin
            out_vld <= 1'b1;
            out_dat <= in_data;
         end else begin
            skid_vld <= 1'b1;
            skid_dat <= in_data;
         end
      end else if (consume) begin
         out_vld <= 1'b0;
      end
   end

   assign in_ready  = ~skid_vld;
   assign out_valid = out_vld;
   assign out_data  = out_dat;
   assign count     = {out_vld & skid_vld, out_vld ^ skid_vld};

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: 1-cycle latency, full throughput, 2-deep skid so id_ready is registered.
// Flush and reset kill held bundles; idle outputs show NOP encodings and never enable writeback.
module id_ex_pipe
   import id_ex_pipe_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int RADDR_W = RADDR_W_DEF,
   parameter int OP_W    = OP_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               id_valid,
   output logic               id_ready,
   input  logic [ADDR_W-1:0]  id_pc,
   input  logic [OP_W-1:0]    id_aluop,
   input  logic [2:0]         id_alufunct3,
   input  logic [6:0]         id_alufunct7,
   input  logic [XLEN-1:0]    id_reg1,
   input  logic [XLEN-1:0]    id_reg2,
   input  logic [XLEN-1:0]    id_imm,
   input  logic               id_wreg,
   input  logic [RADDR_W-1:0] id_wd,
   output logic               ex_valid,
   input  logic               ex_ready,
   output logic [ADDR_W-1:0]  ex_pc,
   output logic [OP_W-1:0]    ex_aluop,
   output logic [2:0]         ex_alufunct3,
   output logic [6:0]         ex_alufunct7,
   output logic [XLEN-1:0]    ex_reg1,
   output logic [XLEN-1:0]    ex_reg2,
   output logic [XLEN-1:0]    ex_imm,
   output logic               ex_wreg,
   output logic [RADDR_W-1:0] ex_wd,
   output logic [1:0]         occupancy
);

   localparam int W = bundle_w(XLEN, ADDR_W, RADDR_W, OP_W);

   logic [W-1:0]       in_bus;
   logic [W-1:0]       out_bus;
   logic               held_vld;
   logic [ADDR_W-1:0]  s_pc;
   logic [OP_W-1:0]    s_aluop;
   logic [2:0]         s_funct3;
   logic [6:0]         s_funct7;
   logic [XLEN-1:0]    s_reg1;
   logic [XLEN-1:0]    s_reg2;
   logic [XLEN-1:0]    s_imm;
   logic               s_wreg;
   logic [RADDR_W-1:0] s_wd;

   assign in_bus = {id_pc, id_aluop, id_alufunct3, id_alufunct7,
                    id_reg1, id_reg2, id_imm, id_wreg, id_wd};

   pipe_skid_buf #(.W(W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (id_valid),
      .in_ready  (id_ready),
      .in_data   (in_bus),
      .out_valid (held_vld),
      .out_ready (ex_ready),
      .out_data  (out_bus),
      .count     (occupancy)
   );

   assign {s_pc, s_aluop, s_funct3, s_funct7,
           s_reg1, s_reg2, s_imm, s_wreg, s_wd} = out_bus;

   // Bubbles present as NOPs; a write to x0 is never a real writeback.
   assign ex_valid     = held_vld;
   assign ex_pc        = held_vld ? s_pc     : ADDR_W'(ZERO_WORD);
   assign ex_aluop     = held_vld ? s_aluop  : OP_W'(ALUOP_NOP);
   assign ex_alufunct3 = held_vld ? s_funct3 : FUNCT3_NOP;
   assign ex_alufunct7 = held_vld ? s_funct7 : FUNCT7_NOP;
   assign ex_reg1      = held_vld ? s_reg1   : XLEN'(ZERO_WORD);
   assign ex_reg2      = held_vld ? s_reg2   : XLEN'(ZERO_WORD);
   assign ex_imm       = held_vld ? s_imm    : XLEN'(ZERO_WORD);
   assign ex_wd        = held_vld ? s_wd     : RADDR_W'(NOP_REG_ADDR);
   assign ex_wreg      = held_vld & s_wreg & (s_wd != '0);

endmodule

// File: tb/tb_id_ex_pipe.sv
// Drives a 64-bit and a default 32-bit id_ex_pipe from one stimulus stream and
// checks both against a queue-based model of the two-entry stage.
module tb_id_ex_pipe;
   import id_ex_pipe_pkg::*;

   typedef struct packed {
      logic [63:0] pc;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] r1;
      logic [63:0] r2;
      logic [63:0] imm;
      logic        wreg;
      logic [4:0]  wd;
   } bun_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;
   logic id_valid = 1'b0;
   logic ex_ready = 1'b0;
   bun_t drv = '0;

   always #5 clk = ~clk;

   logic        rdy64, v64, wreg64;
   logic [63:0] pc64, r1_64, r2_64, imm64;
   logic [6:0]  op64, f7_64;
   logic [2:0]  f3_64;
   logic [4:0]  wd64;
   logic [1:0]  occ64;

   logic        rdy32, v32, wreg32;
   logic [31:0] pc32, r1_32, r2_32, imm32;
   logic [6:0]  op32, f7_32;
   logic [2:0]  f3_32;
   logic [4:0]  wd32;
   logic [1:0]  occ32;

   id_ex_pipe #(.XLEN(64), .ADDR_W(64), .RADDR_W(5), .OP_W(7)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(rdy64),
      .id_pc(drv.pc), .id_aluop(drv.op), .id_alufunct3(drv.f3), .id_alufunct7(drv.f7),
      .id_reg1(drv.r1), .id_reg2(drv.r2), .id_imm(drv.imm), .id_wreg(drv.wreg), .id_wd(drv.wd),
      .ex_valid(v64), .ex_ready(ex_ready),
      .ex_pc(pc64), .ex_aluop(op64), .ex_alufunct3(f3_64), .ex_alufunct7(f7_64),
      .ex_reg1(r1_64), .ex_reg2(r2_64), .ex_imm(imm64), .ex_wreg(wreg64), .ex_wd(wd64),
      .occupancy(occ64)
   );

   id_ex_pipe dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(rdy32),
      .id_pc(drv.pc[31:0]), .id_aluop(drv.op), .id_alufunct3(drv.f3), .id_alufunct7(drv.f7),
      .id_reg1(drv.r1[31:0]), .id_reg2(drv.r2[31:0]), .id_imm(drv.imm[31:0]),
      .id_wreg(drv.wreg), .id_wd(drv.wd),
      .ex_valid(v32), .ex_ready(ex_ready),
      .ex_pc(pc32), .ex_aluop(op32), .ex_alufunct3(f3_32), .ex_alufunct7(f7_32),
      .ex_reg1(r1_32), .ex_reg2(r2_32), .ex_imm(imm32), .ex_wreg(wreg32), .ex_wd(wd32),
      .occupancy(occ32)
   );

   bun_t        q[$];
   logic [63:0] log_pc[$];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bun_t rand_bun();
      bun_t b;
      b.pc   = {$urandom, $urandom};
      b.op   = 7'($urandom);
      b.f3   = 3'($urandom);
      b.f7   = 7'($urandom);
      b.r1   = {$urandom, $urandom};
      b.r2   = {$urandom, $urandom};
      b.imm  = {$urandom, $urandom};
      b.wreg = 1'($urandom);
      b.wd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      return b;
   endfunction

   task automatic check_all();
      bun_t f;
      logic v;
      v = (q.size() > 0);
      f = v ? q[0] : '0;
      chk("valid64", 64'(v64), 64'(v));
      chk("valid32", 64'(v32), 64'(v));
      chk("ready64", 64'(rdy64), 64'(q.size() < 2));
      chk("ready32", 64'(rdy32), 64'(q.size() < 2));
      chk("occ64", 64'(occ64), 64'(q.size()));
      chk("occ32", 64'(occ32), 64'(q.size()));
      chk("pc64", pc64, f.pc);
      chk("pc32", 64'(pc32), {32'h0, f.pc[31:0]});
      chk("op64", 64'(op64), v ? 64'(f.op) : 64'(ALUOP_NOP));
      chk("op32", 64'(op32), v ? 64'(f.op) : 64'(ALUOP_NOP));
      chk("f3_64", 64'(f3_64), v ? 64'(f.f3) : 64'(FUNCT3_NOP));
      chk("f7_64", 64'(f7_64), v ? 64'(f.f7) : 64'(FUNCT7_NOP));
      chk("f7_32", 64'(f7_32), v ? 64'(f.f7) : 64'(FUNCT7_NOP));
      chk("r1_64", r1_64, f.r1);
      chk("r2_64", r2_64, f.r2);
      chk("imm64", imm64, f.imm);
      chk("r1_32", 64'(r1_32), {32'h0, f.r1[31:0]});
      chk("imm32", 64'(imm32), {32'h0, f.imm[31:0]});
      chk("wd64", 64'(wd64), v ? 64'(f.wd) : 64'(NOP_REG_ADDR));
      chk("wreg64", 64'(wreg64), 64'(v && f.wreg && f.wd != 5'd0));
      chk("wreg32", 64'(wreg32), 64'(v && f.wreg && f.wd != 5'd0));
      chk("f3_32", 64'(f3_32), v ? 64'(f.f3) : 64'(FUNCT3_NOP));
   endtask

   // One clock: decide accept/consume from the pre-edge view, apply at the edge, check at negedge.
   task automatic cycle();
      bit   acc;
      bit   con;
      bun_t b;
      acc = id_valid && (q.size() < 2);
      con = (q.size() > 0) && ex_ready;
      b   = drv;
      if (v64 && ex_ready && !flush && rst) log_pc.push_back(pc64);
      @(posedge clk);
      if (!rst || flush) begin
         q.delete();
      end else begin
         if (con) void'(q.pop_front());
         if (acc) q.push_back(b);
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      #1;
      check_all();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cycle();

      // Streaming with ex_ready held high
      ex_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drv      = rand_bun();
         drv.pc   = 64'(i * 4);
         id_valid = 1'b1;
         cycle();
         chk("stream_pc", pc64, 64'(i * 4));
         chk("stream_occ_le1", 64'(occ64 <= 2'd1), 64'd1);
      end
      id_valid = 1'b0;
      cycle();

      // Backpressure: two held, third refused until space opens
      log_pc.delete();
      ex_ready = 1'b0;
      id_valid = 1'b1;
      drv = rand_bun(); drv.pc = 64'h40; cycle();
      drv = rand_bun(); drv.pc = 64'h44; cycle();
      chk("bp_ready_low", 64'(rdy64), 64'd0);
      drv = rand_bun(); drv.pc = 64'h48; cycle();
      chk("bp_occ", 64'(occ64), 64'd2);
      chk("bp_head", pc64, 64'h40);
      ex_ready = 1'b1;
      cycle();
      cycle();
      id_valid = 1'b0;
      cycle();
      cycle();
      chk("bp_count", 64'(log_pc.size()), 64'd3);
      if (log_pc.size() == 3) begin
         chk("bp_order0", log_pc[0], 64'h40);
         chk("bp_order1", log_pc[1], 64'h44);
         chk("bp_order2", log_pc[2], 64'h48);
      end

      // Flush with a bundle offered on the same edge
      ex_ready = 1'b0;
      id_valid = 1'b1;
      drv = rand_bun(); drv.pc = 64'h60; cycle();
      drv = rand_bun(); drv.pc = 64'h64; cycle();
      chk("fl_occ_before", 64'(occ64), 64'd2);
      flush = 1'b1;
      drv = rand_bun(); drv.pc = 64'h80; cycle();
      flush    = 1'b0;
      id_valid = 1'b0;
      chk("fl_valid", 64'(v64), 64'd0);
      chk("fl_occ", 64'(occ64), 64'd0);
      chk("fl_ready", 64'(rdy64), 64'd1);
      log_pc.delete();
      ex_ready = 1'b1;
      repeat (3) cycle();
      chk("fl_nothing_out", 64'(log_pc.size()), 64'd0);

      // Writes to x0 never enable writeback
      ex_ready = 1'b0;
      drv = rand_bun(); drv.wreg = 1'b1; drv.wd = 5'd0;
      id_valid = 1'b1; cycle(); id_valid = 1'b0;
      chk("x0_valid", 64'(v64), 64'd1);
      chk("x0_wreg", 64'(wreg64), 64'd0);
      ex_ready = 1'b1; cycle(); ex_ready = 1'b0;
      drv = rand_bun(); drv.wreg = 1'b1; drv.wd = 5'd5;
      drv.r1 = 64'hFFFF_FFFF_0000_0001;
      id_valid = 1'b1; cycle(); id_valid = 1'b0;
      chk("x5_wreg", 64'(wreg64), 64'd1);
      chk("x5_wd", 64'(wd64), 64'd5);
      chk("wide_r1", r1_64, 64'hFFFF_FFFF_0000_0001);
      chk("narrow_r1", 64'(r1_32), 64'h0000_0001);
      ex_ready = 1'b1; cycle();

      // Asynchronous reset while two bundles are held
      ex_ready = 1'b0;
      id_valid = 1'b1;
      drv = rand_bun(); cycle();
      drv = rand_bun(); cycle();
      chk("rst_occ_before", 64'(occ64), 64'd2);
      #2 rst = 1'b0;
      #1 q.delete();
      chk("rst_valid", 64'(v64), 64'd0);
      chk("rst_ready", 64'(rdy64), 64'd1);
      chk("rst_occ", 64'(occ64), 64'd0);
      check_all();
      @(negedge clk);
      rst      = 1'b1;
      id_valid = 1'b0;
      ex_ready = 1'b1;
      cycle();
      chk("rst_no_ghost", 64'(v64), 64'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         id_valid = ($urandom_range(0, 3) != 0);
         ex_ready = 1'($urandom);
         flush    = ($urandom_range(0, 15) == 0);
         drv      = rand_bun();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter XLEN, 32, data width of reg1/reg2/imm.
REQ-002 Parameter ADDR_W, 32, pc width.
REQ-003 Parameter RADDR_W, 5, destination register address width.
REQ-004 Parameter OP_W, 7, aluop width; funct3 fixed 3 bits, funct7 fixed 7 bits.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 flush  in  1  synchronous kill of all held entries (branch/jump redirect).
REQ-008 id_valid  in  1  decode presents a valid bundle.
REQ-009 id_ready  out  1  stage can accept a bundle this cycle.
REQ-010 id_pc, id_aluop, id_alufunct3, id_alufunct7, id_reg1, id_reg2, id_imm, id_wreg, id_wd  in  ADDR_W/OP_W/3/7/XLEN/XLEN/XLEN/1/RADDR_W  decoded bundle.
REQ-011 ex_valid  out  1  execute-side bundle valid.
REQ-012 ex_ready  in  1  execute consumes the bundle this cycle.
REQ-013 ex_pc, ex_aluop, ex_alufunct3, ex_alufunct7, ex_reg1, ex_reg2, ex_imm, ex_wreg, ex_wd  out  same widths  registered bundle to execute.
REQ-014 occupancy  out  2  number of held bundles, 0..2.

Function
REQ-015 Two entries SHALL be held: output register (drives ex_*) and skid register; order preserved, oldest always in output register.
REQ-016 Accept = id_valid & id_ready; consume = ex_valid & ex_ready; both evaluated on the same edge.
REQ-017 id_ready SHALL be a registered signal equal to (skid entry empty); it SHALL NOT depend combinationally on ex_ready.
REQ-018 Latency: bundle accepted at edge N into empty stage SHALL appear with ex_valid=1 after edge N (one cycle).
REQ-019 Throughput: with ex_ready held 1, one bundle per cycle SHALL pass, skid never used.
REQ-020 Accept while output register full and not consumed SHALL write skid; id_ready falls to 0 next cycle.
REQ-021 Consume with skid full SHALL move skid to output register, skid empties, id_ready rises next cycle; simultaneous accept impossible since id_ready=0.
REQ-022 Consume and accept on same edge with skid empty SHALL load the new bundle into the output register directly.
REQ-023 flush=1 SHALL clear both entries on the edge; a bundle offered that cycle SHALL be dropped; flush wins over accept and consume; next cycle ex_valid=0, id_ready=1, occupancy=0.
REQ-024 ex_wreg SHALL equal stored wreg AND ex_valid AND (stored wd != 0): bubbles and x0 writes never enable writeback.
REQ-025 When ex_valid=0, ex_aluop/funct3/funct7 SHALL show the NOP encodings, ex_wd=0, data fields zero.
REQ-026 occupancy SHALL equal output-valid + skid-valid, updated on the same edge.
REQ-027 Payload fields SHALL be captured unmodified, no width conversion; all widths set only by parameters.

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) clear both valid bits, drive ex_valid=0, ex_wreg=0, ex_wd=0, ex_pc=0, data fields=0, aluop/funct3/funct7=NOP, occupancy=0, id_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard held bundles; no bundle SHALL emerge after release until a new accept.
REQ-030 Release of rst SHALL be synchronised externally; the block needs no first-cycle special case.

Structure
REQ-031 NOP aluop/funct3/funct7 encodings, ZeroWord, NOPRegAddr and default widths SHALL live in the shared defs package.
REQ-032 One sub-module, pipe_skid_buf (parameter W, generic 2-entry valid/ready skid with flush), SHALL hold the packed payload; id_ex_pipe packs/unpacks fields and applies REQ-024/025 gating.

Verification
REQ-033 Reset mid-stream: occupancy=2, drop rst to 0 between edges -> ex_valid=0, id_ready=1, occupancy=0 without a clock edge.
REQ-034 Streaming: 8 bundles pc=0x00..0x1C, ex_ready=1 -> ex_pc sequence 0x00..0x1C on consecutive cycles, one-cycle latency, occupancy<=1.
REQ-035 Backpressure: ex_ready=0, offer pc=0x40, 0x44, 0x48 -> 0x40, 0x44 held, id_ready=0 after 2nd accept, 0x48 not accepted; ex_ready=1 -> 0x40, 0x44, 0x48 emerge in order, none lost or duplicated.
REQ-036 Flush: occupancy=2, flush=1 with id_valid=1 pc=0x80 -> next cycle ex_valid=0, occupancy=0; 0x80 never appears.
REQ-037 x0 suppression: id_wreg=1, id_wd=0 accepted -> ex_valid=1, ex_wreg=0; same with id_wd=5 -> ex_wreg=1, ex_wd=5.
REQ-038 Parameter sweep: XLEN=64, ADDR_W=64 -> REQ-034/035 pass, reg1=0xFFFF_FFFF_0000_0001 delivered intact.
